// File: rtl/pe_requant_pack_pkg.sv
// Shared constants and helpers for the PE requantize-and-pack block.
// The QUANT_RELU_EN macro (see requant_lane) changes the lower clamp bound.
package pe_requant_pack_pkg;

  localparam int IN_BITS    = 32;
  localparam int MULT_BITS  = 16;
  localparam int SHIFT_BITS = 6;
  localparam int ACT_BITS   = 8;
  localparam int LANES      = 8;
  localparam int OUT_BITS   = LANES * ACT_BITS;
  localparam int LANE_BITS  = $clog2(LANES);
  localparam int PROD_BITS  = 49;
  localparam int MAX_SHIFT  = 47;

  // One guard bit for the rounding add, one more for the zero-point add.
  localparam int R_BITS = PROD_BITS + 1;
  localparam int Q_BITS = PROD_BITS + 2;

  localparam logic signed [Q_BITS-1:0] CLAMP_LO = '0;
  localparam logic signed [Q_BITS-1:0] CLAMP_HI = Q_BITS'(255);

  function automatic logic [SHIFT_BITS-1:0] sat_shift(input logic [SHIFT_BITS-1:0] s);
    return (s > SHIFT_BITS'(MAX_SHIFT)) ? SHIFT_BITS'(MAX_SHIFT) : s;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// Three-stage requantizer: scale multiply, rounding shift, zero-point add and clamp.
// Define QUANT_RELU_EN to clamp at zero_point instead of 0 (quantized ReLU).
module requant_lane
  import pe_requant_pack_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic                  flush_i,
  input  logic [IN_BITS-1:0]    sum_i,
  input  logic [MULT_BITS-1:0]  scale_mult_i,
  input  logic [SHIFT_BITS-1:0] scale_shift_i,
  input  logic [ACT_BITS-1:0]   zero_point_i,
  output logic                  valid_o,
  output logic                  flush_o,
  output logic [ACT_BITS-1:0]   byte_o,
  output logic                  busy_o
);

  logic                      s1_valid_q, s2_valid_q, s3_valid_q;
  logic                      s1_flush_q, s2_flush_q, s3_flush_q;
  logic signed [PROD_BITS-1:0] prod_d, prod_q;
  logic signed [R_BITS-1:0]  rnd, biased, r_d, r_q;
  logic signed [Q_BITS-1:0]  zp_ext, lo, q;
  logic [ACT_BITS-1:0]       byte_d, byte_q;
  logic [SHIFT_BITS-1:0]     shift_eff;

  // S1: the multiplier is zero-extended so the product stays signed.
  assign prod_d = PROD_BITS'($signed(sum_i)) * PROD_BITS'($signed({1'b0, scale_mult_i}));

  assign shift_eff = sat_shift(scale_shift_i);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    rnd = '0;
    if (shift_eff != '0) begin
      rnd = R_BITS'(1) << (shift_eff - SHIFT_BITS'(1));
    end
    biased = {prod_q[PROD_BITS-1], prod_q} + rnd;
    r_d    = biased >>> shift_eff;
  end

  always_comb begin
    zp_ext = {{(Q_BITS-ACT_BITS){1'b0}}, zero_point_i};
`ifdef QUANT_RELU_EN
    lo = zp_ext;
`else
    lo = CLAMP_LO;
`endif
    q      = {r_q[R_BITS-1], r_q} + zp_ext;
    byte_d = q[ACT_BITS-1:0];
    if (q < lo) begin
      byte_d = lo[ACT_BITS-1:0];
    end else if (q > CLAMP_HI) begin
      byte_d = CLAMP_HI[ACT_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_flush_q <= 1'b0;
      s2_flush_q <= 1'b0;
      s3_flush_q <= 1'b0;
    end else begin
      s1_valid_q <= valid_i;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      s1_flush_q <= flush_i;
      s2_flush_q <= s1_flush_q;
      s3_flush_q <= s2_flush_q;
    end
  end

  // NOTE: datapath registers have no reset; the valid bits above qualify their contents.
  always_ff @(posedge clk) begin
    prod_q <= prod_d;
    r_q    <= r_d;
    byte_q <= byte_d;
  end

  assign valid_o = s3_valid_q;
  assign flush_o = s3_flush_q;
  assign byte_o  = byte_q;
  assign busy_o  = s1_valid_q | s2_valid_q | s3_valid_q |
                   s1_flush_q | s2_flush_q | s3_flush_q;

endmodule

// File: rtl/pe_requant_pack.sv
// Requantizes PE accumulator results to bytes and packs eight per 64-bit word.
// Optional QUANT_RELU_EN (in requant_lane) raises the lower clamp to zero_point.
module pe_requant_pack
  import pe_requant_pack_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [IN_BITS-1:0]    sum_in,
  input  logic                  flush,
  input  logic [MULT_BITS-1:0]  scale_mult,
  input  logic [SHIFT_BITS-1:0] scale_shift,
  input  logic [ACT_BITS-1:0]   zero_point,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [OUT_BITS-1:0]   out_data,
  output logic                  overflow,
  output logic                  busy
);

  logic                 s3_valid, s3_flush, lane_busy;
  logic [ACT_BITS-1:0]  s3_byte;

  logic [LANE_BITS-1:0] lane_cnt_d, lane_cnt_q;
  logic [LANE_BITS:0]   cnt_sum;
  logic [OUT_BITS-1:0]  word_d, word_q, word_w;
  logic                 word_done, load;

  logic                 out_valid_d, out_valid_q;
  logic [OUT_BITS-1:0]  out_data_d, out_data_q;
  logic                 overflow_d, overflow_q;

  requant_lane u_lane (
    .clk           (clk),
    .reset         (reset),
    .valid_i       (valid_in),
    .flush_i       (flush),
    .sum_i         (sum_in),
    .scale_mult_i  (scale_mult),
    .scale_shift_i (scale_shift),
    .zero_point_i  (zero_point),
    .valid_o       (s3_valid),
    .flush_o       (s3_flush),
    .byte_o        (s3_byte),
    .busy_o        (lane_busy)
  );

  // Packer: the current element is merged before a flush closes the word.
  always_comb begin
    word_w = word_q;
    if (s3_valid) begin
      word_w[{lane_cnt_q, 3'b000} +: ACT_BITS] = s3_byte;
    end
    cnt_sum   = {1'b0, lane_cnt_q} + {{LANE_BITS{1'b0}}, s3_valid};
    word_done = (s3_valid && (lane_cnt_q == LANE_BITS'(LANES - 1))) ||
                (s3_flush && (cnt_sum != '0));
    lane_cnt_d = word_done ? '0 : cnt_sum[LANE_BITS-1:0];
    word_d     = word_done ? '0 : word_w;
  end

  // Holding register: no backpressure upstream, so a blocked word is dropped and flagged.
  always_comb begin
    load        = word_done && (!out_valid_q || out_ready);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = word_w;
    end else if (word_done) begin
      overflow_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_cnt_q  <= '0;
      word_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      lane_cnt_q  <= lane_cnt_d;
      word_q      <= word_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;
  assign busy      = lane_busy | (lane_cnt_q != '0);

endmodule

// File: tb/tb_pe_requant_pack.sv
// Directed bench for pe_requant_pack: requant vector table plus packing,
// flush, backpressure and reset sequences. Honors QUANT_RELU_EN.
module tb_pe_requant_pack;

  logic        clk, reset, valid_in, flush, out_ready;
  logic [31:0] sum_in;
  logic [15:0] scale_mult;
  logic [5:0]  scale_shift;
  logic [7:0]  zero_point;
  logic        out_valid, overflow, busy;
  logic [63:0] out_data;

  pe_requant_pack dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .sum_in      (sum_in),
    .flush       (flush),
    .scale_mult  (scale_mult),
    .scale_shift (scale_shift),
    .zero_point  (zero_point),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .overflow    (overflow),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Accepted words and the cycle they were taken.
  logic [63:0] wq[$];
  int          cq[$];
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      wq.push_back(out_data);
      cq.push_back(cyc);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] wq_at(input int i);
    return (wq.size() > i) ? wq[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic int cq_at(input int i);
    return (cq.size() > i) ? cq[i] : -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [31:0] s, input logic f);
    valid_in = 1'b1;
    sum_in   = s;
    flush    = f;
    step();
    valid_in = 1'b0;
    flush    = 1'b0;
    sum_in   = '0;
  endtask

  task automatic cfg(input logic [15:0] m, input logic [5:0] sh, input logic [7:0] zp);
    scale_mult  = m;
    scale_shift = sh;
    zero_point  = zp;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [31:0] sum;
    logic [15:0] mult;
    logic [5:0]  sh;
    logic [7:0]  zp;
    logic [7:0]  exp;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] s, input logic [15:0] m,
                              input logic [5:0] sh, input logic [7:0] zp,
                              input logic [7:0] e);
    vec_t v;
    v.sum = s; v.mult = m; v.sh = sh; v.zp = zp; v.exp = e;
    return v;
  endfunction

  localparam int NV = 11;
  vec_t tv[NV];

  initial begin
    logic relu;
`ifdef QUANT_RELU_EN
    relu = 1'b1;
`else
    relu = 1'b0;
`endif
    tv[0]  = mk(32'd200,        16'd32768, 6'd16, 8'd3,  8'h67);
    tv[1]  = mk(32'd3,          16'd1,     6'd1,  8'd0,  8'd2);
    tv[2]  = mk(-32'sd3,        16'd1,     6'd1,  8'd0,  8'd0);
    tv[3]  = mk(32'd100000,     16'd1,     6'd0,  8'd0,  8'd255);
    tv[4]  = mk(-32'sd100,      16'd1,     6'd0,  8'd10, relu ? 8'd10 : 8'd0);
    tv[5]  = mk(32'd5,          16'd1,     6'd1,  8'd0,  8'd3);
    tv[6]  = mk(-32'sd5,        16'd1,     6'd1,  8'd10, relu ? 8'd10 : 8'd8);
    tv[7]  = mk(32'h7FFF_FFFF,  16'd65535, 6'd63, 8'd0,  8'd1);
    tv[8]  = mk(32'd249,        16'd1,     6'd0,  8'd5,  8'd254);
    tv[9]  = mk(-32'sd1000,     16'd1,     6'd3,  8'd200, relu ? 8'd200 : 8'd75);
    tv[10] = mk(32'd1000,       16'd300,   6'd12, 8'd4,  8'd77);

    reset = 1'b1; valid_in = 1'b0; flush = 1'b0; sum_in = '0; out_ready = 1'b1;
    cfg(16'd1, 6'd0, 8'd0);
    steps(3);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_data",  out_data, 64'd0);
    check("rst_overflow",  {63'b0, overflow}, 64'd0);
    check("rst_busy",      {63'b0, busy}, 64'd0);
    reset = 1'b0;
    step();

    // Single elements, each flushed on its own into lane 0.
    for (int i = 0; i < NV; i++) begin
      cfg(tv[i].mult, tv[i].sh, tv[i].zp);
      step();
      send(tv[i].sum, 1'b1);
      steps(2);
      check($sformatf("vec%0d_early", i), {63'b0, out_valid}, 64'd0);
      step();
      check($sformatf("vec%0d_valid", i), {63'b0, out_valid}, 64'd1);
      check($sformatf("vec%0d_data", i), out_data, {56'b0, tv[i].exp});
      step();
    end

    cfg(16'd1, 6'd0, 8'd0);
    step();

    // Eight elements fill one word.
    wq.delete(); cq.delete();
    for (int k = 1; k <= 8; k++) send(32'(k), 1'b0);
    steps(6);
    check("pack8_count", 64'(wq.size()), 64'd1);
    check("pack8_word", wq_at(0), 64'h0807060504030201);

    // Sixteen back-to-back elements: two words eight cycles apart.
    wq.delete(); cq.delete();
    for (int k = 0; k < 16; k++) send(32'(8'h10 + k), 1'b0);
    steps(6);
    check("b2b_count", 64'(wq.size()), 64'd2);
    check("b2b_word0", wq_at(0), 64'h1716151413121110);
    check("b2b_word1", wq_at(1), 64'h1F1E1D1C1B1A1918);
    check("b2b_spacing", 64'(cq_at(1) - cq_at(0)), 64'd8);

    // Partial word closed by a flush on its last element.
    wq.delete(); cq.delete();
    send(32'h11, 1'b0);
    send(32'h22, 1'b0);
    send(32'h33, 1'b1);
    check("flush_busy", {63'b0, busy}, 64'd1);
    steps(6);
    check("flush_count", 64'(wq.size()), 64'd1);
    check("flush_word", wq_at(0), 64'h0000000000332211);
    check("flush_idle_after", {63'b0, busy}, 64'd0);

    // Flush with nothing pending produces no word.
    wq.delete(); cq.delete();
    flush = 1'b1;
    step();
    flush = 1'b0;
    steps(6);
    check("idle_flush_count", 64'(wq.size()), 64'd0);
    check("idle_flush_valid", {63'b0, out_valid}, 64'd0);
    check("idle_flush_busy", {63'b0, busy}, 64'd0);

    // Backpressure: second word is dropped, first held, overflow sticks.
    wq.delete(); cq.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(32'(8'h40 + k), 1'b0);
    steps(4);
    check("bp_first_valid", {63'b0, out_valid}, 64'd1);
    check("bp_first_data", out_data, 64'h4746454443424140);
    check("bp_no_ovf_yet", {63'b0, overflow}, 64'd0);
    for (int k = 0; k < 8; k++) send(32'(8'h50 + k), 1'b0);
    steps(4);
    check("bp_held_valid", {63'b0, out_valid}, 64'd1);
    check("bp_held_data", out_data, 64'h4746454443424140);
    check("bp_overflow", {63'b0, overflow}, 64'd1);
    out_ready = 1'b1;
    step();
    check("bp_consumed_count", 64'(wq.size()), 64'd1);
    check("bp_consumed_word", wq_at(0), 64'h4746454443424140);
    check("bp_valid_drop", {63'b0, out_valid}, 64'd0);
    steps(3);
    check("bp_overflow_sticky", {63'b0, overflow}, 64'd1);
    do_reset();
    check("bp_overflow_cleared", {63'b0, overflow}, 64'd0);

    // Reset mid-word discards the partial data.
    send(32'h71, 1'b0);
    send(32'h72, 1'b0);
    send(32'h73, 1'b0);
    steps(4);
    check("midrst_busy_before", {63'b0, busy}, 64'd1);
    do_reset();
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_data", out_data, 64'd0);
    wq.delete(); cq.delete();
    for (int k = 0; k < 8; k++) send(32'(8'h80 + k), 1'b0);
    steps(6);
    check("midrst_count", 64'(wq.size()), 64'd1);
    check("midrst_word", wq_at(0), 64'h8786858483828180);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
